// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Latency: n/a (package only).
// Backpressure: n/a. Build option MIPS_CTRL_LOGIC_IMM_EN enables the andi/ori/xori dispatch.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADR   = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WR    = 4'd6,
        R_EX      = 4'd7,
        R_WB      = 4'd8,
        BEQ_EX    = 4'd9,
        ADDI_EX   = 4'd10,
        IMM_WB    = 4'd11,
        J_EX      = 4'd12,
        LOGI_EX   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LOGI  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;  // PC + 4 straight from the ALU
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // branch target latched in DECODE
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Control word produced by the state decoder. fetch_gate marks the state whose
    // IR/PC write strobes must be qualified with MemReady.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_op;
        logic       fetch_gate;
    } ctrl_t;

    // DECODE dispatch target; unsupported opcodes return FETCH, which is also
    // how the top recognises an illegal instruction.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_RTYPE:      nxt = R_EX;
            OP_LW, OP_SW:  nxt = MEM_ADR;
            OP_BEQ:        nxt = BEQ_EX;
            OP_ADDI:       nxt = ADDI_EX;
            OP_J:          nxt = J_EX;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            OP_ANDI, OP_ORI, OP_XORI: nxt = LOGI_EX;
`endif
            default:       nxt = FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure state -> control-word decoder for the multicycle MIPS control FSM.
// Latency: combinational, zero cycles.
// Backpressure: none; MemReady gating of fetch strobes is applied by the top.
import mips_ctrl_pkg::*;

module mips_ctrl_outdec (
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.ext_op = 1'b1;
        case (state)
            INIT: begin
                ctrl.ext_op = 1'b0;           // everything quiet out of reset
            end
            FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.ir_write   = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.fetch_gate = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.pc_src     = PCSRC_ALU;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2; // speculative branch target
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            BEQ_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
            ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
`ifdef MIPS_CTRL_LOGIC_IMM_EN
            LOGI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_LOGI;
                ctrl.ext_op    = 1'b0;         // logical immediates are zero-extended
            end
`endif
            IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            J_EX: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state logic, strobe gating.
// Latency: Moore outputs decoded from the state register; FETCH IR/PC writes and Illegal react same cycle.
// Backpressure: MemReady stalls FETCH, MEM_RD and MEM_WR. Build option MIPS_CTRL_LOGIC_IMM_EN adds andi/ori/xori.
// Ports: clk, rst_n (async active-low); Opcode/Funct from IR; Zero from ALU; MemReady from memory;
//        PC, memory, register-file, ALU mux, extender and Illegal controls out.
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       ExtOp,
    output logic       Illegal
);

    state_t state;
    state_t dispatch;
    ctrl_t  ctrl;
    logic   strobe_ok;
    logic   unused_funct;

    // Funct is resolved by the ALU decoder, not here.
    assign unused_funct = ^Funct;
    assign dispatch     = decode_dispatch(Opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            case (state)
                INIT:    state <= FETCH;
                FETCH:   if (MemReady) state <= DECODE;
                DECODE:  state <= dispatch;
                MEM_ADR: state <= (Opcode == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD:  if (MemReady) state <= MEM_WB;
                MEM_WB:  state <= FETCH;
                MEM_WR:  if (MemReady) state <= FETCH;
                R_EX:    state <= R_WB;
                R_WB:    state <= FETCH;
                BEQ_EX:  state <= FETCH;
                ADDI_EX: state <= IMM_WB;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
                LOGI_EX: state <= IMM_WB;
`endif
                IMM_WB:  state <= FETCH;
                J_EX:    state <= FETCH;
                default: state <= INIT;
            endcase
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // In FETCH the IR load and PC+4 commit only on the cycle memory returns data.
    assign strobe_ok = ~ctrl.fetch_gate | MemReady;

    assign PCWrite  = ctrl.pc_write & strobe_ok;
    assign IRWrite  = ctrl.ir_write & strobe_ok;
    assign Branch   = ctrl.branch;
    assign PCEn     = PCWrite | (ctrl.branch & Zero);
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSrc    = ctrl.pc_src;
    assign ExtOp    = ctrl.ext_op;
    // A DECODE that dispatches back to FETCH means the opcode is unsupported.
    assign Illegal  = (state == DECODE) && (dispatch == FETCH);

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences one shared ALU, one unified memory port, and the 16→32 immediate extender through fetch, decode, execute, memory and write-back steps. It issues every datapath enable and mux select from the current state, including the extender mode (sign or zero). It sits between the instruction register (opcode/funct) and the datapath muxes, register file, PC and memory interface.

## Interface
- No parameters.
- clk  in  1  core clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26], valid from DECODE onward
- Funct  in  6  IR[5:0] (informational; ALU decoder consumes it)
- Zero  in  1  ALU zero flag, valid in BEQ_EX
- MemReady  in  1  memory completes the current access this cycle
- PCWrite, Branch  out  1  unconditional / conditional PC write
- PCEn  out  1  PCWrite | (Branch & Zero)
- IorD, MemRead, MemWrite, IRWrite  out  1  memory address select and strobes
- RegDst, MemtoReg, RegWrite  out  1  register-file controls
- ALUSrcA  out  1; ALUSrcB  out  2; ALUOp  out  2; PCSrc  out  2
- ExtOp  out  1  1 = sign-extend immediate, 0 = zero-extend
- Illegal  out  1  one-cycle pulse in DECODE on unsupported opcode

## Operation
- States: INIT, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, BEQ_EX, ADDI_EX, IMM_WB, J_EX, LOGI_EX.
- Reset → INIT. All outputs are 0 in INIT. INIT → FETCH unconditionally.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite assert only while MemReady=1. Hold while MemReady=0. Go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1 (branch target). Dispatch on Opcode:
  - 000000 → R_EX
  - 100011, 101011 → MEM_ADR
  - 000100 → BEQ_EX
  - 001000 → ADDI_EX
  - 000010 → J_EX
  - 001100/001101/001110 → LOGI_EX
  - anything else → Illegal=1, then FETCH
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: IorD=1, MemRead=1. Hold until MemReady, then → MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEM_WR: IorD=1, MemWrite=1. Hold until MemReady, then → FETCH.
- R_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01 → FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1 → IMM_WB.
- LOGI_EX: as ADDI_EX but ALUOp=11 and ExtOp=0 → IMM_WB.
- IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- J_EX: PCWrite=1, PCSrc=10 → FETCH.
- Any output not listed for a state is 0. ExtOp defaults to 1.

## Timing
- Moore outputs, decoded combinationally from the state register. Exception: FETCH IRWrite/PCWrite are gated by MemReady.
- Cycles per instruction with MemReady tied high: lw 5, sw 4, R-type 4, addi/logic-imm 4, beq 3, j 3. Each stall cycle adds 1.
- MemReady is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
- rst_n low forces INIT immediately, mid-instruction included. All strobes drop the same cycle. No partial write-back completes.
- Illegal is high only during the single DECODE cycle. The PC has already advanced by 4.

## Configuration
- MIPS_CTRL_LOGIC_IMM_EN defined: andi/ori/xori decode to LOGI_EX with ExtOp=0 and ALUOp=11.
- Undefined: LOGI_EX is not built, and those opcodes take the Illegal path.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4-bit encoding)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ANDI, OP_ORI, OP_XORI)
  - ALUOp codes (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10, ALU_LOGI=11)
  - PCSrc/ALUSrcB codes
- Sub-module mips_ctrl_outdec: pure state→control-word decoder. The top holds the state register and next-state logic.

## Test plan
- Reset released, MemReady=1, Opcode=100011 → INIT, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB. RegWrite=1 and MemtoReg=1 only in cycle 6; back in FETCH at cycle 7.
- sw with MemReady low for 3 cycles in MEM_WR → MemWrite high 4 cycles; FETCH follows the ready cycle.
- beq with Zero=1, then with Zero=0 → PCEn=1 / PCEn=0 in BEQ_EX; PCSrc=01 both times.
- ori (001101) with macro defined → ExtOp=0 and ALUOp=11 in LOGI_EX. Without the macro → Illegal pulse, then FETCH.
- Opcode=111111 → Illegal=1 for exactly one cycle; no RegWrite/MemWrite; next state FETCH.
- rst_n dropped during MEM_WB → RegWrite falls asynchronously, all outputs 0. After release: INIT, then FETCH.
